// File: rtl/ppb_pkg.sv
// Shared types and constants for the PPB serial link (command frames in, status frames out).
package ppb_pkg;

  localparam int RX_PAYLOAD_BYTES = 8;
  localparam int TX_PAYLOAD_BYTES = 15;

  localparam logic [7:0] DEF_SYNC_RX = 8'hA5;
  localparam logic [7:0] DEF_SYNC_TX = 8'h5A;

  typedef enum logic [1:0] {RX_SYNC, RX_DATA, RX_CHK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA, TX_CHK} tx_state_t;

endpackage

// File: rtl/ppb_xor_acc.sv
// Running XOR of a byte stream; cleared at frame start, folded in on each payload byte.
module ppb_xor_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (clr)
      acc <= '0;
    else if (en)
      acc <= acc ^ din;
  end

endmodule

// File: rtl/ppb_link.sv
// PPB link: parses command frames into device_inputs and emits periodic/requested status frames.
// Build option: define PPB_LINK_CHECKSUM_EN to check/generate the XOR checksum byte.
module ppb_link
  import ppb_pkg::*;
#(
  parameter int         TX_PERIOD = 100000,
  parameter logic [7:0] SYNC_RX   = DEF_SYNC_RX,
  parameter logic [7:0] SYNC_TX   = DEF_SYNC_TX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [0:59]  device_inputs,
  input  logic [0:119] device_outputs,
  input  logic         tx_req,
  output logic         frame_ok,
  output logic         frame_err
);

  localparam int              PW          = $clog2(TX_PERIOD);
  localparam logic [PW-1:0]   PERIOD_LAST = PW'(TX_PERIOD - 1);
  localparam logic [2:0]      RX_LAST     = 3'(RX_PAYLOAD_BYTES - 1);
  localparam logic [3:0]      TX_LAST     = 4'(TX_PAYLOAD_BYTES - 1);

  // ---------------- receive path ----------------
  rx_state_t rx_state, rx_state_n;
  logic [2:0]  rx_cnt;
  logic [0:63] rx_shadow;
  logic [7:0]  rx_acc;
  logic        rx_xfer, rx_sync_hit, rx_data_take, rx_chk_take, rx_chk_ok;

  assign rx_ready = !reset;
  assign rx_xfer  = rx_valid && rx_ready;

`ifdef PPB_LINK_CHECKSUM_EN
  assign rx_chk_ok = (rx_data == rx_acc);
`else
  assign rx_chk_ok = 1'b1;
`endif

  always_comb begin
    rx_state_n   = rx_state;
    rx_sync_hit  = 1'b0;
    rx_data_take = 1'b0;
    rx_chk_take  = 1'b0;
    case (rx_state)
      RX_SYNC: if (rx_xfer && rx_data == SYNC_RX) begin
        rx_sync_hit = 1'b1;
        rx_state_n  = RX_DATA;
      end
      // A sync value here is ordinary payload; no mid-frame resync.
      RX_DATA: if (rx_xfer) begin
        rx_data_take = 1'b1;
        if (rx_cnt == RX_LAST)
          rx_state_n = RX_CHK;
      end
      RX_CHK: if (rx_xfer) begin
        rx_chk_take = 1'b1;
        rx_state_n  = RX_SYNC;
      end
      default: rx_state_n = RX_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state      <= RX_SYNC;
      rx_cnt        <= '0;
      device_inputs <= '0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      frame_ok  <= rx_chk_take && rx_chk_ok;
      frame_err <= rx_chk_take && !rx_chk_ok;
      if (rx_sync_hit)
        rx_cnt <= '0;
      else if (rx_data_take)
        rx_cnt <= rx_cnt + 3'd1;
      if (rx_chk_take && rx_chk_ok)
        device_inputs <= rx_shadow[0:59];
    end
  end

  always_ff @(posedge clk) begin
    if (rx_data_take)
      rx_shadow[{rx_cnt, 3'b000} +: 8] <= rx_data;
  end

  ppb_xor_acc #(.DATA_W(8)) u_rx_acc (
    .clk (clk),
    .clr (reset || rx_sync_hit),
    .en  (rx_data_take),
    .din (rx_data),
    .acc (rx_acc)
  );

  // ---------------- transmit path ----------------
  tx_state_t tx_state, tx_state_n;
  logic [3:0]    tx_cnt;
  logic [PW-1:0] period_cnt;
  logic          tx_pend, tx_expire, tx_idle, tx_start, tx_data_take;
  logic [0:119]  tx_snap;
  logic [7:0]    tx_acc, tx_chk;

  assign tx_expire = (period_cnt == PERIOD_LAST);
  assign tx_idle   = (tx_state == TX_IDLE);
  assign tx_start  = tx_idle && (tx_expire || tx_req || tx_pend);

`ifdef PPB_LINK_CHECKSUM_EN
  assign tx_chk = tx_acc;
`else
  assign tx_chk = 8'h00;
`endif

  always_comb begin
    tx_state_n   = tx_state;
    tx_data_take = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    case (tx_state)
      TX_IDLE: if (tx_start) tx_state_n = TX_SYNC;
      TX_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_TX;
        if (tx_ready) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        tx_valid = 1'b1;
        tx_data  = tx_snap[{tx_cnt, 3'b000} +: 8];
        if (tx_ready) begin
          tx_data_take = 1'b1;
          if (tx_cnt == TX_LAST)
            tx_state_n = TX_CHK;
        end
      end
      TX_CHK: begin
        tx_valid = 1'b1;
        tx_data  = tx_chk;
        if (tx_ready) tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Requests and period expiries while busy coalesce into a single pending frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      period_cnt <= '0;
      tx_pend    <= 1'b0;
    end else begin
      tx_state   <= tx_state_n;
      period_cnt <= (tx_start || tx_expire) ? '0 : period_cnt + 1'b1;
      if (tx_start)
        tx_pend <= 1'b0;
      else if (!tx_idle && (tx_req || tx_expire))
        tx_pend <= 1'b1;
      if (tx_start)
        tx_cnt <= '0;
      else if (tx_data_take)
        tx_cnt <= tx_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_start)
      tx_snap <= device_outputs;
  end

  ppb_xor_acc #(.DATA_W(8)) u_tx_acc (
    .clk (clk),
    .clr (reset || tx_start),
    .en  (tx_data_take),
    .din (tx_data),
    .acc (tx_acc)
  );

  logic unused_bits;
`ifdef PPB_LINK_CHECKSUM_EN
  assign unused_bits = ^rx_shadow[60:63];
`else
  assign unused_bits = ^{rx_shadow[60:63], rx_acc, tx_acc};
`endif

endmodule

// File: tb/tb_ppb_link.sv
// Scoreboard bench for ppb_link: directed command/status frames, stalls, coalesced requests, reset.
module tb_ppb_link;

  localparam int P = 200;
`ifdef PPB_LINK_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [0:59]  device_inputs;
  logic [0:119] dev_out = '0;
  logic         tx_req = 1'b0;
  logic         frame_ok, frame_err;

  always #5 clk = ~clk;

  ppb_link #(.TX_PERIOD(P)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .device_inputs  (device_inputs),
    .device_outputs (dev_out),
    .tx_req         (tx_req),
    .frame_ok       (frame_ok),
    .frame_err      (frame_err)
  );

  typedef struct packed {
    logic        ok;
    logic        err;
    logic [59:0] di;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] tx_q[$];
  int n_chk = 0;
  int n_fail = 0;

  localparam logic [119:0] DA = 120'h0102030405060708090A0B0C0D0E0F;
  localparam logic [119:0] DB = 120'h112233445566778899AABBCCDDEEFF;
  localparam logic [59:0]  DI_BIT0 = 60'h800000000000000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic ok, input logic err, input logic [59:0] di);
    ev_t e;
    e.ok = ok;
    e.err = err;
    e.di = di;
    ev_q.push_back(e);
  endtask

  task automatic push_tx_frame(input logic [119:0] d);
    logic [7:0] b, chk;
    chk = 8'h00;
    tx_q.push_back(8'h5A);
    for (int k = 0; k < 15; k++) begin
      b = d[119-8*k -: 8];
      chk = chk ^ b;
      tx_q.push_back(b);
    end
    tx_q.push_back(CK ? chk : 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] pl, input logic [7:0] chk);
    send_byte(8'hA5);
    for (int k = 0; k < 8; k++) send_byte(pl[63-8*k -: 8]);
    send_byte(chk);
  endtask

  task automatic pulse_req();
    tx_req = 1'b1;
    @(posedge clk);
    #1 tx_req = 1'b0;
  endtask

  task automatic wait_tx_done(input string name, input int bound);
    int n = 0;
    while (tx_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    check(name, 128'(tx_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  // Transmit monitor: compare every accepted byte and the hold behaviour under back-pressure.
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  always @(negedge clk) begin
    if (stall_prev && !reset) begin
      check("tx_hold_valid", 128'(tx_valid), 128'(1));
      check("tx_hold_data", 128'(tx_data), 128'(stall_data));
    end
    if (!reset && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL tx_extra: got byte %0h, expected none", tx_data);
      end else begin
        check("tx_byte", 128'(tx_data), 128'(tx_q.pop_front()));
      end
    end
    stall_prev = tx_valid && !tx_ready && !reset;
    stall_data = tx_data;
  end

  // Receive monitor: every frame_ok/frame_err pulse must match a queued frame result.
  always @(negedge clk) begin
    if (!reset && (frame_ok || frame_err)) begin
      if (ev_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rx_unexpected: got ok=%0b err=%0b, expected no pulse", frame_ok, frame_err);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        check("rx_ok", 128'(frame_ok), 128'(e.ok));
        check("rx_err", 128'(frame_err), 128'(e.err));
        check("rx_di", 128'(device_inputs), 128'(e.di));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", 128'(rx_ready), 128'(0));
    check("rst_tx_valid", 128'(tx_valid), 128'(0));
    check("rst_tx_data", 128'(tx_data), 128'(0));
    check("rst_di", 128'(device_inputs), 128'(0));
    check("rst_ok", 128'(frame_ok), 128'(0));
    check("rst_err", 128'(frame_err), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rx_ready_run", 128'(rx_ready), 128'(1));
    @(posedge clk);
    #1;

    // Command frames: good, bad checksum, leading junk.
    push_ev(1'b1, 1'b0, DI_BIT0);
    send_frame(64'h8000000000000000, 8'h80);
    push_ev(!CK, CK, DI_BIT0);
    send_frame(64'h8000000000000000, 8'h00);
    push_ev(1'b1, 1'b0, 60'h0123456789ABCDE);
    send_byte(8'h12);
    send_byte(8'h34);
    send_frame(64'h0123456789ABCDEF, 8'h00);
    repeat (3) @(posedge clk);
    #1;

    // Status frame under back-pressure; snapshot must survive a device_outputs change.
    dev_out = DA;
    tx_ready = 1'b0;
    push_tx_frame(DA);
    pulse_req();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_sync_valid", 128'(tx_valid), 128'(1));
      check("t1_sync_data", 128'(tx_data), 128'(8'h5A));
    end
    dev_out = DB;
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_tx_done("t1_done", 100);

    // Coalesced requests plus a concurrent command frame carrying a sync byte as payload.
    push_tx_frame(DB);
    push_tx_frame(DB);
    pulse_req();
    fork
      begin
        push_ev(1'b1, 1'b0, 60'hA5000000000000F);
        send_frame(64'hA5000000000000F0, 8'h55);
      end
      begin
        repeat (3) begin
          @(posedge clk);
          #1 tx_req = 1'b1;
          @(posedge clk);
          #1 tx_req = 1'b0;
        end
      end
      begin
        for (int i = 0; i < 24; i++) begin
          tx_ready = (i % 3 != 2);
          @(posedge clk);
          #1;
        end
        tx_ready = 1'b1;
      end
    join
    wait_tx_done("t2_done", 150);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t2_no_third", 128'(tx_valid), 128'(0));
    @(posedge clk);
    #1;

    // Reset in the middle of both a status frame and a command frame.
    tx_ready = 1'b0;
    pulse_req();
    send_byte(8'hA5);
    repeat (4) send_byte(8'hFF);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_di", 128'(device_inputs), 128'(0));
    check("mid_rst_tx_valid", 128'(tx_valid), 128'(0));
    reset = 1'b0;
    tx_ready = 1'b1;
    push_tx_frame(DB);
    n = 0;
    fork
      begin
        do begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end while (!tx_valid && n < P + 50);
      end
      begin
        @(posedge clk);
        #1;
        push_ev(1'b1, 1'b0, DI_BIT0);
        send_frame(64'h8000000000000000, 8'h80);
      end
    join
    check("period_edges", 128'(n), 128'(P));
    wait_tx_done("auto_done", 100);

    repeat (3) @(posedge clk);
    check("ev_q_empty", 128'(ev_q.size()), 128'(0));
    check("tx_q_empty", 128'(tx_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
